ddr_rd_burst_ctrl: RTL and testbench
====================================

// Module: ddr_rd_burst_ctrl
// PURPOSE
//  Upstream feeder of the 256->64 read-side DDR FIFO in the video output path.
//  On each frame_start it reads one frame from DDR as AXI4 INCR bursts and writes every returned
//  256-bit beat into the FIFO. It throttles on the FIFO write water level so the FIFO never overflows.
// PARAMETERS
//  ADDR_WIDTH        28      AXI byte address width
//  DATA_WIDTH        256     AXI R data width = FIFO write width
//  FIFO_DEPTH_WIDTH  9       FIFO write-side depth = 2^9 = 512 words
//  BURST_LEN         16      beats per full burst, 1..256
//  FRAME_BEATS       129600  beats per frame (1920x1080x16b/256)
// PORTS
//  clk                 in   1              system clock, shared with FIFO
//  rst                 in   1              async reset, active-high
//  frame_start         in   1              1-cycle pulse: begin reading a frame
//  frame_base_addr     in   ADDR_WIDTH     frame byte address, sampled with frame_start
//  busy                out  1              frame transfer in progress
//  frame_done          out  1              1-cycle pulse after last beat of frame written
//  err                 out  1              sticky rlast/beat-count mismatch; cleared by frame_start
//  m_arvalid           out  1              AXI AR valid
//  m_arready           in   1              AXI AR ready
//  m_araddr            out  ADDR_WIDTH     AXI AR address
//  m_arlen             out  8              AXI AR length (beats-1)
//  m_rvalid            in   1              AXI R valid
//  m_rready            out  1              AXI R ready
//  m_rdata             in   DATA_WIDTH     AXI R data
//  m_rlast             in   1              AXI R last
//  fifo_wr_en          out  1              FIFO write enable
//  fifo_wr_data        out  DATA_WIDTH     FIFO write data
//  fifo_wr_water_level in   FIFO_DEPTH_WIDTH+1  FIFO fill level, write side
//  fifo_wr_full        in   1              FIFO full, safety stop only
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, frame_done=0, err=0, m_arvalid=0, m_araddr=0, m_arlen=0, m_rready=0, fifo_wr_en=0.
//  - FSM: IDLE -> WAIT_SPACE -> ADDR -> DATA -> WAIT_SPACE (if beats remain) or DONE -> IDLE.
//  - IDLE: frame_start loads addr=frame_base_addr, remain=FRAME_BEATS, clears err, sets busy=1, goes to WAIT_SPACE.
//  - WAIT_SPACE: len = min(BURST_LEN, remain). Go to ADDR when (2^FIFO_DEPTH_WIDTH - fifo_wr_water_level) >= len.
//    WAIT_SPACE lasts >= 1 cycle, so the level already includes the previous burst's final write.
//  - ADDR: m_arvalid=1, m_araddr=addr, m_arlen=len-1, all held stable until m_arready.
//    On the handshake: addr += len*(DATA_WIDTH/8), remain -= len, beat_cnt=len, go to DATA.
//  - DATA: m_rready = ~fifo_wr_full. fifo_wr_en = m_rvalid & m_rready, combinational.
//    fifo_wr_data = m_rdata, 0-cycle latency. Each write decrements beat_cnt.
//  - Burst end: the beat with beat_cnt==1 ends the burst. If m_rlast != (beat_cnt==1) on any beat, set err.
//    Exit on beat count, not on rlast.
//  - Exactly one burst outstanding at a time. No AR issued while DATA is active.
//  - DONE: frame_done=1 for one cycle, busy=0, go to IDLE.
//  - frame_start while busy: ignored, no effect on address/counters.
//  - Last burst is short when FRAME_BEATS is not a multiple of BURST_LEN, e.g. 129600 % 16 = 0 -> none.
//  - Address arithmetic wraps modulo 2^ADDR_WIDTH. No 4KB split: the caller aligns the base so bursts stay within 4KB.
//  - Mid-operation reset returns to reset state immediately. The AXI slave is reset in the same domain.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/WAIT_SPACE/ADDR/DATA/DONE) and BYTES_PER_BEAT = DATA_WIDTH/8.
//  - Single flat module, no sub-module; the FIFO is instantiated alongside at the top level.
// TESTING
//  1. FRAME_BEATS=64, BURST_LEN=16, base 0x1000, always-ready slave
//     -> 4 ARs at 0x1000/0x1200/0x1400/0x1600, arlen=15; 64 writes; frame_done once; err=0.
//  2. FRAME_BEATS=40 -> ARs with arlen 15,15,7; 40 FIFO writes total.
//  3. Preload water_level=500, no reads -> no AR issued.
//     Drop level to 496 -> AR issued within 2 cycles.
//  4. Slave asserts rlast on beat 15 of 16 -> err=1 sticky; FSM still completes on beat count; next frame_start clears err.
//  5. Random rvalid gaps, random arready delay, fifo_wr_full pulses
//     -> no write while full; data order preserved; beat count exact.
//  6. rst asserted mid-DATA -> all outputs at reset values next edge.
//     Fresh frame_start after release -> clean transfer.

Source files
------------

// File: rtl/ddr_rd_burst_ctrl_pkg.sv
// Shared definitions for the DDR read-burst feeder of the video output FIFO.
//   state_e         : controller FSM state encoding
//   BYTES_PER_BEAT  : byte stride of one beat at the default 256-bit data width
//   bytes_per_beat(): byte stride of one beat for an arbitrary data width
package ddr_rd_burst_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StAddr,
    StData,
    StDone
  } state_e;

  localparam int unsigned DATA_WIDTH_DFLT = 256;
  localparam int unsigned BYTES_PER_BEAT  = DATA_WIDTH_DFLT / 8;

  function automatic int unsigned bytes_per_beat(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ddr_rd_burst_ctrl.sv
// Reads one video frame from DDR as AXI4 INCR bursts on every frame_start and pushes each returned
// beat straight into the write side of the read FIFO, throttled on the FIFO water level.
//
// Ports
//   clk, rst              : system clock (shared with FIFO), async active-high reset
//   frame_start           : 1-cycle pulse, start a frame (ignored while busy)
//   frame_base_addr       : frame byte address, sampled with frame_start
//   busy                  : frame transfer in progress
//   frame_done            : 1-cycle pulse after the last beat of the frame was written
//   err                   : sticky rlast/beat-count mismatch, cleared by the next frame_start
//   m_ar*                 : AXI4 read address channel (master side)
//   m_r*                  : AXI4 read data channel (master side)
//   fifo_wr_en/_data      : FIFO write port, combinational pass-through of R beats
//   fifo_wr_water_level   : FIFO fill level on the write side
//   fifo_wr_full          : FIFO full, back-pressures R as a safety stop
module ddr_rd_burst_ctrl
  import ddr_rd_burst_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 28,
  parameter int unsigned DATA_WIDTH       = 256,
  parameter int unsigned FIFO_DEPTH_WIDTH = 9,
  parameter int unsigned BURST_LEN        = 16,
  parameter int unsigned FRAME_BEATS      = 129600
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [ADDR_WIDTH-1:0]       frame_base_addr,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        err,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [ADDR_WIDTH-1:0]       m_araddr,
  output logic [7:0]                  m_arlen,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [DATA_WIDTH-1:0]       m_rdata,
  input  logic                        m_rlast,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  input  logic [FIFO_DEPTH_WIDTH:0]   fifo_wr_water_level,
  input  logic                        fifo_wr_full
);

  localparam int unsigned DepthWords = 32'd1 << FIFO_DEPTH_WIDTH;
  localparam int unsigned RemW       = $clog2(FRAME_BEATS + 1);
  localparam int unsigned BeatBytes  = bytes_per_beat(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RemW-1:0]       remain_q, remain_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;

  logic [8:0]            len;
  logic                  space_ok;
  logic                  last_beat;

  // Length of the next burst: full burst, or whatever is left of the frame.
  always_comb begin
    if (32'(remain_q) < BURST_LEN) begin
      len = 9'(remain_q);
    end else begin
      len = 9'(BURST_LEN);
    end
  end

  // Free words must cover the whole burst; the slave can stream it without gaps.
  assign space_ok  = (32'(fifo_wr_water_level) + 32'(len)) <= DepthWords;
  assign last_beat = (beat_cnt_q == 9'd1);

  // Outputs
  always_comb begin
    busy         = (state_q == StWaitSpace) || (state_q == StAddr) || (state_q == StData);
    frame_done   = (state_q == StDone);
    err          = err_q;
    m_arvalid    = (state_q == StAddr);
    m_araddr     = addr_q;
    m_arlen      = (state_q == StAddr) ? 8'(len - 9'd1) : 8'd0;
    m_rready     = (state_q == StData) && !fifo_wr_full;
    fifo_wr_en   = m_rvalid && m_rready;
    fifo_wr_data = m_rdata;
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          addr_d   = frame_base_addr;
          remain_d = RemW'(FRAME_BEATS);
          err_d    = 1'b0;
          state_d  = StWaitSpace;
        end
      end
      StWaitSpace: begin
        if (space_ok) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        // len is derived from remain_q, which is frozen here, so arlen stays stable.
        if (m_arready) begin
          addr_d     = addr_q + ADDR_WIDTH'(32'(len) * BeatBytes);
          remain_d   = remain_q - RemW'(len);
          beat_cnt_d = len;
          state_d    = StData;
        end
      end
      StData: begin
        if (fifo_wr_en) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          if (m_rlast != last_beat) begin
            err_d = 1'b1;
          end
          // Burst ends on our own count; a misplaced rlast only flags err.
          if (last_beat) begin
            state_d = (remain_q == '0) ? StDone : StWaitSpace;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      remain_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ddr_rd_burst_ctrl.sv
// Bench for ddr_rd_burst_ctrl: two instances (64-beat and 40-beat frames) share one behavioural
// AXI slave / FIFO model; a select bit routes the slave to the instance under test.
module tb_ddr_rd_burst_ctrl;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 256;

  logic          clk;
  logic          rst;
  logic          sel64;
  logic          frame_start;
  logic [AW-1:0] frame_base_addr;
  logic          m_arready;
  logic          m_rvalid;
  logic          m_rlast;
  logic [DW-1:0] m_rdata;
  logic [9:0]    fifo_wr_water_level;
  logic          fifo_wr_full;

  // Per-instance gated inputs and raw outputs
  logic          fs_a, ar_rdy_a, rv_a, fs_b, ar_rdy_b, rv_b;
  logic          busy_a, done_a, err_a, arvalid_a, rready_a, wren_a;
  logic          busy_b, done_b, err_b, arvalid_b, rready_b, wren_b;
  logic [AW-1:0] araddr_a, araddr_b;
  logic [7:0]    arlen_a, arlen_b;
  logic [DW-1:0] wdata_a, wdata_b;

  // Views of the selected instance
  logic          busy, frame_done, err, m_arvalid, m_rready, fifo_wr_en;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [DW-1:0] fifo_wr_data;

  assign fs_a     = frame_start & sel64;
  assign ar_rdy_a = m_arready & sel64;
  assign rv_a     = m_rvalid & sel64;
  assign fs_b     = frame_start & ~sel64;
  assign ar_rdy_b = m_arready & ~sel64;
  assign rv_b     = m_rvalid & ~sel64;

  assign busy         = sel64 ? busy_a    : busy_b;
  assign frame_done   = sel64 ? done_a    : done_b;
  assign err          = sel64 ? err_a     : err_b;
  assign m_arvalid    = sel64 ? arvalid_a : arvalid_b;
  assign m_araddr     = sel64 ? araddr_a  : araddr_b;
  assign m_arlen      = sel64 ? arlen_a   : arlen_b;
  assign m_rready     = sel64 ? rready_a  : rready_b;
  assign fifo_wr_en   = sel64 ? wren_a    : wren_b;
  assign fifo_wr_data = sel64 ? wdata_a   : wdata_b;

  ddr_rd_burst_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(9), .BURST_LEN(16), .FRAME_BEATS(64)
  ) dut64 (
    .clk(clk), .rst(rst), .frame_start(fs_a), .frame_base_addr(frame_base_addr),
    .busy(busy_a), .frame_done(done_a), .err(err_a),
    .m_arvalid(arvalid_a), .m_arready(ar_rdy_a), .m_araddr(araddr_a), .m_arlen(arlen_a),
    .m_rvalid(rv_a), .m_rready(rready_a), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .fifo_wr_en(wren_a), .fifo_wr_data(wdata_a),
    .fifo_wr_water_level(fifo_wr_water_level), .fifo_wr_full(fifo_wr_full)
  );

  ddr_rd_burst_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(9), .BURST_LEN(16), .FRAME_BEATS(40)
  ) dut40 (
    .clk(clk), .rst(rst), .frame_start(fs_b), .frame_base_addr(frame_base_addr),
    .busy(busy_b), .frame_done(done_b), .err(err_b),
    .m_arvalid(arvalid_b), .m_arready(ar_rdy_b), .m_araddr(araddr_b), .m_arlen(arlen_b),
    .m_rvalid(rv_b), .m_rready(rready_b), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .fifo_wr_en(wren_b), .fifo_wr_data(wdata_b),
    .fifo_wr_water_level(fifo_wr_water_level), .fifo_wr_full(fifo_wr_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave / FIFO model state
  logic [AW-1:0] ar_addr_log[$];
  int unsigned   ar_len_log[$];
  int unsigned   burst_q[$];
  int unsigned   beat_idx, data_seq, exp_seq, n_writes, n_done;
  int unsigned   lvl_lo, lvl_hi, lvl_thresh;
  bit            rnd, rlast_fault, fs_pending, rv_hold;
  int            checks, failures;

  typedef struct {
    int unsigned   level;
    logic [AW-1:0] base;
    bit            exp_go;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [DW-1:0] mk_data(input int unsigned s);
    return {8{s ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    ar_addr_log.delete();
    ar_len_log.delete();
    burst_q.delete();
    beat_idx = 0; data_seq = 0; exp_seq = 0; n_writes = 0; n_done = 0;
    lvl_lo = 0; lvl_hi = 0; lvl_thresh = 32'hFFFF_FFFF;
    rnd = 0; rlast_fault = 0; fs_pending = 0; rv_hold = 0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1; frame_start = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
    fifo_wr_full = 1'b0; m_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},     256'(busy),       256'(0));
    chk({tag, "_done"},     256'(frame_done), 256'(0));
    chk({tag, "_err"},      256'(err),        256'(0));
    chk({tag, "_arvalid"},  256'(m_arvalid),  256'(0));
    chk({tag, "_araddr"},   256'(m_araddr),   256'(0));
    chk({tag, "_arlen"},    256'(m_arlen),    256'(0));
    chk({tag, "_rready"},   256'(m_rready),   256'(0));
    chk({tag, "_wr_en"},    256'(fifo_wr_en), 256'(0));
  endtask

  // One clock: drive at negedge, observe handshakes 1 time unit later.
  task automatic cycle();
    @(negedge clk);
    frame_start = fs_pending;
    fs_pending = 0;
    fifo_wr_water_level = 10'((n_writes >= lvl_thresh) ? lvl_hi : lvl_lo);
    m_arready = rnd ? ($urandom_range(2, 0) == 0) : 1'b1;
    fifo_wr_full = rnd ? ($urandom_range(4, 0) == 0) : 1'b0;
    if (!rv_hold) begin
      if (burst_q.size() > 0 && (!rnd || $urandom_range(1, 0) == 1)) begin
        m_rvalid = 1'b1;
        m_rdata  = mk_data(data_seq);
        m_rlast  = rlast_fault ? (beat_idx == 14) : (beat_idx == burst_q[0] - 1);
      end else begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rdata  = '0;
      end
    end
    #1;
    if (fifo_wr_en) begin
      chk("no_write_while_full", 256'(fifo_wr_full), 256'(0));
      chk("wr_data_order", fifo_wr_data, mk_data(exp_seq));
      exp_seq++;
      n_writes++;
    end
    if (m_rvalid && m_rready) begin
      beat_idx++;
      data_seq++;
      if (burst_q.size() > 0 && beat_idx == burst_q[0]) begin
        void'(burst_q.pop_front());
        beat_idx = 0;
        rlast_fault = 0;
      end
      rv_hold = 0;
    end else begin
      rv_hold = m_rvalid;
    end
    if (m_arvalid && m_arready) begin
      chk("single_outstanding", 256'(burst_q.size()), 256'(0));
      ar_addr_log.push_back(m_araddr);
      ar_len_log.push_back(int'(m_arlen));
      burst_q.push_back(int'(m_arlen) + 1);
    end
    if (frame_done) n_done++;
  endtask

  task automatic start_frame(input bit use64, input logic [AW-1:0] base);
    sel64 = use64;
    frame_base_addr = base;
    fs_pending = 1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      cycle();
      k++;
    end
    chk({tag, "_done_seen"}, 256'(n_done), 256'(1));
    repeat (3) cycle();
  endtask

  // Expected AR sequence from the frame geometry: bursts of 16 until the frame runs out.
  task automatic check_frame(input string tag, input logic [AW-1:0] base, input int unsigned nbeats,
                             input bit exp_err);
    int unsigned   rem, l, i;
    logic [AW-1:0] a;
    rem = nbeats;
    a = base;
    i = 0;
    chk({tag, "_ar_count"}, 256'(ar_addr_log.size()), 256'((nbeats + 15) / 16));
    while (rem > 0) begin
      l = (rem < 16) ? rem : 16;
      if (i < ar_addr_log.size()) begin
        chk($sformatf("%s_ar%0d_addr", tag, i), 256'(ar_addr_log[i]), 256'(a));
        chk($sformatf("%s_ar%0d_len", tag, i), 256'(ar_len_log[i]), 256'(l - 1));
      end
      a = a + AW'(l * 32);
      rem = rem - l;
      i++;
    end
    chk({tag, "_writes"}, 256'(n_writes), 256'(nbeats));
    chk({tag, "_done_once"}, 256'(n_done), 256'(1));
    chk({tag, "_err"}, 256'(err), 256'(exp_err));
    chk({tag, "_idle"}, 256'(busy), 256'(0));
  endtask

  initial begin
    logic [AW-1:0] base;
    int k;
    checks = 0;
    failures = 0;
    vecs[0] = '{level: 0,   base: 28'h0001000, exp_go: 1'b1};
    vecs[1] = '{level: 496, base: 28'h0002000, exp_go: 1'b1};
    vecs[2] = '{level: 497, base: 28'h0003000, exp_go: 1'b0};
    vecs[3] = '{level: 512, base: 28'h0004000, exp_go: 1'b0};
    vecs[4] = '{level: 480, base: 28'hFFFF000, exp_go: 1'b1};
    vecs[5] = '{level: 511, base: 28'h0005000, exp_go: 1'b0};

    sel64 = 1'b1; rst = 1'b1; frame_start = 1'b0; frame_base_addr = '0; m_arready = 1'b0;
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; fifo_wr_water_level = '0; fifo_wr_full = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    hard_reset();

    // Space threshold vectors: first burst needs 16 free words.
    for (int i = 0; i < 6; i++) begin
      hard_reset();
      lvl_lo = vecs[i].level;
      start_frame(1'b1, vecs[i].base);
      repeat (6) cycle();
      chk($sformatf("vec%0d_busy", i), 256'(busy), 256'(1));
      chk($sformatf("vec%0d_ar_issued", i), 256'(ar_addr_log.size()), 256'(vecs[i].exp_go));
      if (vecs[i].exp_go && ar_addr_log.size() > 0) begin
        chk($sformatf("vec%0d_araddr", i), 256'(ar_addr_log[0]), 256'(vecs[i].base));
      end
    end
    hard_reset();

    // 64-beat frame, always-ready slave
    start_frame(1'b1, 28'h0001000);
    wait_done("f64", 400);
    check_frame("f64", 28'h0001000, 64, 1'b0);

    // 40-beat frame; final 8-beat burst must start with exactly 8 free words
    reset_model();
    lvl_hi = 504;
    lvl_thresh = 32;
    start_frame(1'b0, 28'h0002000);
    wait_done("f40", 400);
    check_frame("f40", 28'h0002000, 40, 1'b0);

    // Water-level hold-off, then release
    reset_model();
    lvl_lo = 500;
    start_frame(1'b1, 28'h0003000);
    repeat (20) cycle();
    chk("wl_hold_no_ar", 256'(ar_addr_log.size()), 256'(0));
    chk("wl_hold_busy", 256'(busy), 256'(1));
    lvl_lo = 496;
    repeat (2) cycle();
    chk("wl_release_ar", 256'(ar_addr_log.size()), 256'(1));
    lvl_lo = 0;
    wait_done("wl", 400);
    check_frame("wl", 28'h0003000, 64, 1'b0);

    // Early rlast: sticky err, frame still completes on count; next start clears err
    reset_model();
    rlast_fault = 1;
    start_frame(1'b1, 28'h0004000);
    wait_done("rlast", 400);
    check_frame("rlast", 28'h0004000, 64, 1'b1);
    reset_model();
    start_frame(1'b1, 28'h0005000);
    repeat (2) cycle();
    chk("err_cleared", 256'(err), 256'(0));
    wait_done("clean", 400);
    check_frame("clean", 28'h0005000, 64, 1'b0);

    // Randomised handshakes and full pulses
    for (int r = 0; r < 3; r++) begin
      reset_model();
      rnd = 1;
      base = {16'($urandom_range(0, 16'hFFFF)), 12'h000};
      start_frame(r[0] == 1'b0, base);
      wait_done($sformatf("rnd%0d", r), 4000);
      rnd = 0;
      check_frame($sformatf("rnd%0d", r), base, (r[0] == 1'b0) ? 64 : 40, 1'b0);
    end

    // Reset in the middle of DATA, then a fresh frame
    reset_model();
    start_frame(1'b1, 28'h0006000);
    k = 0;
    while (n_writes < 20 && k < 200) begin
      cycle();
      k++;
    end
    chk("mid_reached_data", 256'(n_writes >= 20), 256'(1));
    @(negedge clk);
    rst = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_rst_held");
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    start_frame(1'b1, 28'h0007000);
    wait_done("post_rst", 400);
    check_frame("post_rst", 28'h0007000, 64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
